// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between four register-file requesters and the
// round-robin write arbiter. The master side belongs to the requesters
// and the slave side belongs to the arbiter.
interface regfile_wr_arbiter_if;
    logic         iEna;     // arbiter enable, high = grants allowed
    logic [3:0]   iReq;     // request per requester k, bit k
    logic [19:0]  iAddr;    // requester k address in bits [5k+4:5k]
    logic [127:0] iWdata;   // requester k data in bits [32k+31:32k]
    logic [3:0]   oGnt;     // one-hot grant, high for the WRITE cycle
    logic [31:0]  oWe;      // one-hot register-file write enable
    logic [31:0]  oWdata;   // granted write data
    logic         oValid;   // high during WRITE, even for register 0
    logic         oBusy;    // high while in WRITE

    modport master (
        output iEna, iReq, iAddr, iWdata,
        input  oGnt, oWe, oWdata, oValid, oBusy
    );

    modport slave (
        input  iEna, iReq, iAddr, iWdata,
        output oGnt, oWe, oWdata, oValid, oBusy
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write arbiter for a 32-entry register file with four
// requesters. A grant produces a single WRITE cycle followed by at least
// one IDLE cycle. Every output comes straight from a flop; register 0 is
// hard-wired, so a write to it is granted and flagged valid but produces
// no write enable.
module regfile_wr_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t       state_q;
    logic [1:0]   ptr_q;
    logic [3:0]   gnt_q;
    logic [31:0]  we_q;
    logic [31:0]  wdata_q;
    logic         valid_q;
    logic         busy_q;

    logic         found_s;
    logic [1:0]   win_s;
    logic [1:0]   idx_s;
    logic [4:0]   win_addr_s;
    logic [31:0]  win_data_s;

    // Decode a register address into a one-hot write enable; register 0
    // is read-only, so its enable is suppressed.
    function automatic logic [31:0] decode_we(input logic [4:0] addr);
        logic [31:0] we;
        if (addr == 5'd0) begin
            we = 32'h0000_0000;
        end else begin
            we = 32'h0000_0001 << addr;
        end
        return we;
    endfunction

    // One-hot encoding of a requester index.
    function automatic logic [3:0] onehot4(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

    // Round-robin search starting at ptr; the first requester asking wins.
    always_comb begin
        found_s = 1'b0;
        win_s   = 2'd0;
        idx_s   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx_s = ptr_q + i[1:0];
            if (!found_s && bus.iReq[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Steer the winning requester's address and data slices.
    always_comb begin
        win_addr_s = 5'd0;
        win_data_s = 32'h0000_0000;
        case (win_s)
            2'd0: begin
                win_addr_s = bus.iAddr[4:0];
                win_data_s = bus.iWdata[31:0];
            end
            2'd1: begin
                win_addr_s = bus.iAddr[9:5];
                win_data_s = bus.iWdata[63:32];
            end
            2'd2: begin
                win_addr_s = bus.iAddr[14:10];
                win_data_s = bus.iWdata[95:64];
            end
            2'd3: begin
                win_addr_s = bus.iAddr[19:15];
                win_data_s = bus.iWdata[127:96];
            end
            default: begin
                win_addr_s = 5'd0;
                win_data_s = 32'h0000_0000;
            end
        endcase
    end

    // Two-state grant FSM with registered outputs; requests are only
    // sampled in IDLE, and WRITE always lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            we_q    <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.iEna && found_s) begin
                        state_q <= ST_WRITE;
                        ptr_q   <= win_s + 2'd1;
                        gnt_q   <= onehot4(win_s);
                        we_q    <= decode_we(win_addr_s);
                        wdata_q <= win_data_s;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        gnt_q   <= 4'b0000;
                        we_q    <= 32'h0000_0000;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 4'b0000;
                    we_q    <= 32'h0000_0000;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 4'b0000;
                    we_q    <= 32'h0000_0000;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oGnt   = gnt_q;
    assign bus.oWe    = we_q;
    assign bus.oWdata = wdata_q;
    assign bus.oValid = valid_q;
    assign bus.oBusy  = busy_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed testbench for regfile_wr_arbiter. Inputs change on the falling
// edge, and outputs are sampled on the falling edge as well, half a
// period away from the rising edge where the DUT updates.
module tb_regfile_wr_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    regfile_wr_arbiter_if bus ();

    regfile_wr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with its expected value and log any mismatch.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int k, input logic [4:0] addr, input logic [31:0] data);
        bus.iAddr[5*k +: 5]    = addr;
        bus.iWdata[32*k +: 32] = data;
    endtask

    task automatic expect_idle(input string tag);
        check_eq({tag, "_gnt"},   {28'h0, bus.oGnt}, 32'h0);
        check_eq({tag, "_we"},    bus.oWe,           32'h0);
        check_eq({tag, "_valid"}, {31'h0, bus.oValid}, 32'h0);
        check_eq({tag, "_busy"},  {31'h0, bus.oBusy},  32'h0);
    endtask

    task automatic expect_write(input string tag, input logic [3:0] gnt,
                                input logic [31:0] we, input logic [31:0] data);
        check_eq({tag, "_gnt"},   {28'h0, bus.oGnt},   {28'h0, gnt});
        check_eq({tag, "_we"},    bus.oWe,             we);
        check_eq({tag, "_wdata"}, bus.oWdata,          data);
        check_eq({tag, "_valid"}, {31'h0, bus.oValid}, 32'h1);
        check_eq({tag, "_busy"},  {31'h0, bus.oBusy},  32'h1);
    endtask

    task automatic do_reset();
        bus.iEna   = 1'b0;
        bus.iReq   = 4'b0000;
        bus.iAddr  = 20'h0;
        bus.iWdata = 128'h0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int rr_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.iEna   = 1'b0;
        bus.iReq   = 4'b0000;
        bus.iAddr  = 20'h0;
        bus.iWdata = 128'h0;

        // Reset state.
        @(negedge clk);
        expect_idle("reset");
        check_eq("reset_wdata", bus.oWdata, 32'h0);
        rst = 1'b0;

        // Single request from requester 2 to register 7.
        bus.iEna = 1'b1;
        set_slot(2, 5'd7, 32'hDEAD_BEEF);
        bus.iReq = 4'b0100;
        @(negedge clk);
        expect_write("single", 4'b0100, 32'h0000_0080, 32'hDEAD_BEEF);
        bus.iReq = 4'b0000;
        @(negedge clk);
        expect_idle("single_after");
        check_eq("single_hold", bus.oWdata, 32'hDEAD_BEEF);

        // Round-robin with all four requesters asking continuously.
        do_reset();
        for (int k = 0; k < 4; k++) set_slot(k, 5'(8 + k), 32'hA000_0000 + k);
        bus.iEna = 1'b1;
        bus.iReq = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            expect_write($sformatf("rr%0d", n), 4'b0001 << rr_order[n],
                         32'h1 << (8 + rr_order[n]), 32'hA000_0000 + rr_order[n]);
            @(negedge clk);
            expect_idle($sformatf("rr%0d_gap", n));
        end

        // Write to register 0 is granted but has no write enable.
        do_reset();
        bus.iEna = 1'b1;
        set_slot(0, 5'd0, 32'h1234_5678);
        bus.iReq = 4'b0001;
        @(negedge clk);
        expect_write("reg0", 4'b0001, 32'h0, 32'h1234_5678);

        // Boundary addresses 31 and 1 (pointer now at 1).
        set_slot(1, 5'd31, 32'h3131_3131);
        bus.iReq = 4'b0010;
        @(negedge clk);
        expect_idle("reg0_after");
        @(negedge clk);
        expect_write("addr31", 4'b0010, 32'h8000_0000, 32'h3131_3131);
        set_slot(2, 5'd1, 32'h0101_0101);
        bus.iReq = 4'b0100;
        @(negedge clk);
        expect_idle("addr31_after");
        @(negedge clk);
        expect_write("addr1", 4'b0100, 32'h0000_0002, 32'h0101_0101);
        bus.iReq = 4'b0000;

        // Enable gating.
        do_reset();
        set_slot(0, 5'd3, 32'h0000_0033);
        set_slot(1, 5'd4, 32'h0000_0044);
        bus.iReq = 4'b0011;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            expect_idle($sformatf("ena_off%0d", n));
        end
        bus.iEna = 1'b1;
        @(negedge clk);
        expect_write("ena_on", 4'b0001, 32'h0000_0008, 32'h0000_0033);
        bus.iEna = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            expect_idle($sformatf("ena_drop%0d", n));
        end

        // Asynchronous reset in the middle of a WRITE.
        do_reset();
        bus.iEna = 1'b1;
        set_slot(2, 5'd10, 32'hCAFE_0010);
        set_slot(1, 5'd5, 32'h0000_0555);
        bus.iReq = 4'b0100;
        @(negedge clk);
        expect_write("pre_rst", 4'b0100, 32'h0000_0400, 32'hCAFE_0010);
        #1 rst = 1'b1;
        #1;
        expect_idle("async_rst");
        check_eq("async_rst_wdata", bus.oWdata, 32'h0);
        bus.iReq = 4'b1010;
        #1 rst = 1'b0;
        @(negedge clk);
        expect_write("post_rst", 4'b0010, 32'h0000_0020, 32'h0000_0555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
